mem_stage: RTL

- Pipeline stage directly downstream of the execute stage. Consumes the ALU result, store data, memory controls, atomic flag, byte mask and resolved branch/jump targets.
- Performs data-memory access over a req/gnt/rvalid handshake: load extraction and extension, store lane shifting, LL/SC reservation.
- Issues control-flow redirects.
- Registers results into the MEM/WB boundary; stalls the upstream pipeline for variable-latency memory.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/mem_align.sv | 45 ++++
 rtl/mem_stage.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   mem_state_t  : memory-access FSM states (IDLE / REQ / WAIT)
//   MASK_*       : access-width byte masks carried from execute
//   opcodes      : load/store/atomic primary opcodes (instruction[31:26])
//   LINK_REG     : destination register written by jal
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,   // no access outstanding
    REQ  = 2'd1,   // request raised, waiting for dmem_gnt
    WAIT = 2'd2    // load granted, waiting for dmem_rvalid
  } mem_state_t;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Bit 2 of the opcode (instruction[28]) distinguishes the unsigned loads.
  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2B;
  localparam logic [5:0] LL  = 6'h30;
  localparam logic [5:0] SC  = 6'h38;

  localparam logic [4:0] LINK_REG = 5'd31;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic for the MEM stage.
//   byte_off    : address bits [1:0] of the access
//   mask        : access width (MASK_B / MASK_H / MASK_W)
//   unsigned_ld : 1 = zero-extend the loaded value, 0 = sign-extend
//   st_data     : register value to be stored (right-aligned)
//   ld_raw      : full 32-bit word returned by memory
//   be          : byte enables for the bus
//   st_lanes    : store data moved onto its byte lanes
//   ld_data     : extracted and extended load result
//   misaligned  : half on an odd address or word on a non-word address
module mem_align
  import mips_pkg::*;
(
  input  logic [1:0]  byte_off,
  input  logic [3:0]  mask,
  input  logic        unsigned_ld,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [31:0] shifted;
  logic        sign_b;
  logic        sign_h;

  always_comb begin
    be       = mask << byte_off;
    st_lanes = st_data << {byte_off, 3'b000};
    // Bring the addressed byte lane down to bit 0 before width masking.
    shifted  = ld_raw >> {byte_off, 3'b000};
    sign_b   = ~unsigned_ld & shifted[7];
    sign_h   = ~unsigned_ld & shifted[15];
    case (mask)
      MASK_B:  ld_data = {{24{sign_b}}, shifted[7:0]};
      MASK_H:  ld_data = {{16{sign_h}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
    misaligned = ((mask == MASK_H) && byte_off[0]) ||
                 ((mask == MASK_W) && (byte_off != 2'b00));
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access, LL/SC reservation, control-flow
// redirect and the MEM/WB pipeline register.
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   *_in                       : execute-stage results and controls
//   dmem_req/we/addr/be/wdata  : request channel, held stable until dmem_gnt
//   dmem_gnt                   : request accepted
//   dmem_rvalid/rdata          : read response (one per granted load)
//   mem_stall                  : upstream must hold its registers this cycle
//   redirect_valid/target      : flush younger instructions and load new PC
//   align_err                  : misaligned access seen (no bus request made)
//   *_out                      : MEM/WB register contents
//   dbg_state                  : current memory FSM state
//
// Handshake: a request transfers on a cycle where dmem_req && dmem_gnt;
// dmem_req never drops and addr/be/wdata never change while a request is
// waiting for gnt. A granted load completes on the first dmem_rvalid, which
// comes no earlier than the cycle after the grant. dmem_rvalid seen outside
// WAIT is ignored.
module mem_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] LINK_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction_in,
  input  logic        regDst_in,
  input  logic        regWrite_in,
  input  logic        memRead_in,
  input  logic        memWrite_in,
  input  logic        memToReg_in,
  input  logic        atomic_in,
  input  logic        jal_in,
  input  logic        branch_in,
  input  logic        jump_in,
  input  logic        jr_in,
  input  logic [3:0]  mMask_in,
  input  logic [31:0] aluRes_in,
  input  logic [31:0] rsData_in,
  input  logic [31:0] rtData_in,
  input  logic [31:0] branchTarget_in,
  input  logic [31:0] jumpTarget_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_target,
  output logic        align_err,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic [31:0] aluRes_out,
  output logic [31:0] memData_out,
  output logic [4:0]  writeReg_out,
  output logic        regWrite_out,
  output logic        memToReg_out,
  output mem_state_t  dbg_state
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  mem_state_t  state_q, state_d;
  logic        res_valid_q, res_valid_d;
  logic [29:0] res_addr_q, res_addr_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdata_q, mdata_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        regwrite_q, regwrite_d;
  logic        memtoreg_q, memtoreg_d;

  // ---------------------------------------------------------------------
  // Operation decode
  // ---------------------------------------------------------------------
  logic        mem_op;
  logic        is_ll;
  logic        is_sc;
  logic        sc_ok;
  logic        misaligned;
  logic        valid_op;
  logic        complete;
  logic        busy;
  logic [29:0] word_addr;
  logic [31:0] ld_data;

  assign mem_op    = memRead_in | memWrite_in;
  assign is_ll     = atomic_in & memRead_in;
  assign is_sc     = atomic_in & memWrite_in;
  assign word_addr = aluRes_in[31:2];
  assign sc_ok     = res_valid_q && (res_addr_q == word_addr);

  // A failing SC never touches memory; it finishes in one cycle with result 0.
  assign valid_op  = mem_op & ~misaligned & ~(is_sc & ~sc_ok);

  mem_align u_align (
    .byte_off    (aluRes_in[1:0]),
    .mask        (mMask_in),
    .unsigned_ld (instruction_in[28]),
    .st_data     (rtData_in),
    .ld_raw      (dmem_rdata),
    .be          (dmem_be),
    .st_lanes    (dmem_wdata),
    .ld_data     (ld_data),
    .misaligned  (misaligned)
  );

  assign dmem_addr = {aluRes_in[31:2], 2'b00};

  // ---------------------------------------------------------------------
  // Memory FSM: next state and request outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_op) begin
          dmem_req = 1'b1;
          if (dmem_gnt) begin
            // Stores finish on the grant; loads still owe a response.
            if (memWrite_in) complete = 1'b1;
            else             state_d  = WAIT;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt) begin
          if (memWrite_in) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem_we   = dmem_req & memWrite_in;
  // Outside IDLE an access is always outstanding, whatever the inputs show.
  assign busy      = (state_q != IDLE) | valid_op;
  assign mem_stall = busy & ~complete;
  assign align_err = (state_q == IDLE) & mem_op & misaligned;
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------
  // Redirect: held back while a memory op is still in flight
  // ---------------------------------------------------------------------
  always_comb begin
    redirect_valid  = (jr_in | jump_in | branch_in) & ~mem_stall;
    redirect_target = branchTarget_in;
    if (jr_in)        redirect_target = rsData_in;
    else if (jump_in) redirect_target = jumpTarget_in;
  end

  // ---------------------------------------------------------------------
  // LL/SC reservation
  // ---------------------------------------------------------------------
  always_comb begin
    res_valid_d = res_valid_q;
    res_addr_d  = res_addr_q;
    if (!mem_stall) begin
      if (is_sc) begin
        res_valid_d = 1'b0;
      end else if (is_ll && valid_op) begin
        res_valid_d = 1'b1;
        res_addr_d  = word_addr;
      end else if (memWrite_in && valid_op && (res_addr_q == word_addr)) begin
        res_valid_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // MEM/WB register: stage result when not stalled, bubble while stalled
  // ---------------------------------------------------------------------
  always_comb begin
    pc_d       = '0;
    instr_d    = '0;
    alu_d      = '0;
    mdata_d    = '0;
    wreg_d     = '0;
    regwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    if (!mem_stall) begin
      pc_d       = pc_in;
      instr_d    = instruction_in;
      if (jal_in)     alu_d = pc_in + LINK_OFFSET;
      else if (is_sc) alu_d = {31'd0, sc_ok};
      else            alu_d = aluRes_in;
      // An unstalled valid load is necessarily the rvalid cycle.
      if (memRead_in && valid_op) mdata_d = ld_data;
      if (jal_in)         wreg_d = LINK_REG;
      else if (regDst_in) wreg_d = instruction_in[15:11];
      else                wreg_d = instruction_in[20:16];
      regwrite_d = regWrite_in & ~(mem_op & misaligned);
      memtoreg_d = memToReg_in & ~is_sc & ~(mem_op & misaligned);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
      pc_q        <= '0;
      instr_q     <= '0;
      alu_q       <= '0;
      mdata_q     <= '0;
      wreg_q      <= '0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_valid_q <= res_valid_d;
      res_addr_q  <= res_addr_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      alu_q       <= alu_d;
      mdata_q     <= mdata_d;
      wreg_q      <= wreg_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
    end
  end

  assign pc_out          = pc_q;
  assign instruction_out = instr_q;
  assign aluRes_out      = alu_q;
  assign memData_out     = mdata_q;
  assign writeReg_out    = wreg_q;
  assign regWrite_out    = regwrite_q;
  assign memToReg_out    = memtoreg_q;

endmodule
